// File: rtl/mem_io_ctrl.sv
// Data-side memory/IO controller: RAM pass-through plus MMIO TX/RX byte FIFOs.
// Optional cycle counter at CYCLES is built when DBG_CYCLE_COUNTER_EN is defined.
module mem_io_ctrl #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_wr,
    input  logic        cpu_en,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    output logic        ram_en,
    input  logic [31:0] ram_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int TCW = $clog2(TX_DEPTH + 1);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int RCW = $clog2(RX_DEPTH + 1);
    localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
    localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);

    logic           mmio;
    logic           acc;
    logic           sel_tx;
    logic           sel_rx;
    logic           sel_st;
    logic           sel_cyc;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp;
    logic [TAW-1:0] tx_rp;
    logic [TCW-1:0] tx_count;
    logic           tx_full;
    logic           tx_empty;
    logic           tx_push;
    logic           tx_pop;

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp;
    logic [RAW-1:0] rx_rp;
    logic [RCW-1:0] rx_count;
    logic           rx_full;
    logic           rx_avail;
    logic           rx_push;
    logic           rx_pop;
    logic           rx_ovf;
    logic           ovf_set;
    logic           st_rd;

    logic [31:0]    status;
    logic [31:0]    cycle_val;
    logic [31:0]    mmio_rdata;

    assign mmio    = cpu_addr[31:28] == 4'hF;
    assign acc     = cpu_en & mmio;
    assign sel_tx  = cpu_addr[3:0] == 4'h0;
    assign sel_rx  = cpu_addr[3:0] == 4'h4;
    assign sel_st  = cpu_addr[3:0] == 4'h8;
    assign sel_cyc = cpu_addr[3:0] == 4'hC;

    assign ram_addr  = cpu_addr[31:2];
    assign ram_wdata = cpu_wdata;
    assign ram_en    = cpu_en & ~mmio;
    assign ram_we    = ram_en & cpu_wr;

    assign tx_full   = tx_count == TX_FULL_CNT;
    assign tx_empty  = tx_count == '0;
    assign tx_valid  = ~tx_empty;
    assign tx_data   = tx_mem[tx_rp];
    assign tx_pop    = tx_valid & tx_ready;
    // Full is judged on registered count, so a same-cycle pop cannot free a slot.
    assign cpu_stall = acc & cpu_wr & sel_tx & tx_full;
    assign tx_push   = acc & cpu_wr & sel_tx & ~tx_full;

    assign rx_full  = rx_count == RX_FULL_CNT;
    assign rx_avail = rx_count != '0;
    assign rx_pop   = acc & ~cpu_wr & sel_rx & rx_avail;
    assign rx_push  = rx_valid & (~rx_full | rx_pop);
    assign ovf_set  = rx_valid & rx_full & ~rx_pop;
    assign st_rd    = acc & ~cpu_wr & sel_st;

    assign status = {20'b0, 4'(tx_count), 4'(rx_count),
                     rx_ovf, rx_avail, tx_empty, tx_full};

    always_comb begin
        mmio_rdata = '0;
        unique case (1'b1)
            sel_rx:  mmio_rdata = rx_avail ? {24'b0, rx_mem[rx_rp]}
                                           : 32'hFFFF_FFFF;
            sel_st:  mmio_rdata = status;
            sel_cyc: mmio_rdata = cycle_val;
            default: mmio_rdata = '0;
        endcase
    end

    assign cpu_rdata = mmio ? mmio_rdata : ram_rdata;

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wp] <= cpu_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_wp <= tx_wp + TAW'(1);
            end
            if (tx_pop) begin
                tx_rp <= tx_rp + TAW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TCW'(1);
                2'b01:   tx_count <= tx_count - TCW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wp] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
            rx_ovf   <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_wp <= rx_wp + RAW'(1);
            end
            if (rx_pop) begin
                rx_rp <= rx_rp + RAW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + RCW'(1);
                2'b01:   rx_count <= rx_count - RCW'(1);
                default: rx_count <= rx_count;
            endcase
            // A fresh overflow wins over the clear-on-read of STATUS.
            if (ovf_set) begin
                rx_ovf <= 1'b1;
            end else if (st_rd) begin
                rx_ovf <= 1'b0;
            end
        end
    end

`ifdef DBG_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign cycle_val = cycle_cnt;
`else
    assign cycle_val = '0;
`endif

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: vector table, directed FIFO corner cases,
// and random traffic checked against a queue-based model.
module tb_mem_io_ctrl;

    localparam int TXD = 8;
    localparam int RXD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_wr;
    logic        cpu_en;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_en;
    logic [31:0] ram_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;

    always #5 clk = ~clk;

    mem_io_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wr(cpu_wr), .cpu_en(cpu_en),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_en(ram_en), .ram_rdata(ram_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    byte unsigned txq[$];
    byte unsigned rxq[$];
    bit           m_ovf;
    logic [31:0]  m_cyc;
    bit           synced = 0;

    logic [31:0] got_rd;
    logic        got_stall;
    logic        got_txv;
    logic [7:0]  got_txd;
    logic        got_we;
    logic [29:0] got_ra;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {20'b0, 4'(txq.size()), 4'(rxq.size()), m_ovf,
                rxq.size() != 0, txq.size() == 0, txq.size() == TXD};
    endfunction

    function automatic logic [31:0] m_rdata();
        if (cpu_addr[31:28] != 4'hF) return ram_rdata;
        case (cpu_addr[3:0])
            4'h4: return rxq.size() != 0 ? {24'b0, rxq[0]} : 32'hFFFF_FFFF;
            4'h8: return m_status();
`ifdef DBG_CYCLE_COUNTER_EN
            4'hC: return m_cyc;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step();
        bit mmio, t_push, t_pop, r_pop, s_rd, r_full;
        if (!rst) begin
            txq.delete();
            rxq.delete();
            m_ovf  = 0;
            m_cyc  = 0;
            synced = 1;
            return;
        end
        mmio   = cpu_addr[31:28] == 4'hF;
        t_push = cpu_en && mmio && cpu_wr && cpu_addr[3:0] == 4'h0
                 && txq.size() < TXD;
        t_pop  = txq.size() > 0 && tx_ready;
        r_pop  = cpu_en && mmio && !cpu_wr && cpu_addr[3:0] == 4'h4
                 && rxq.size() > 0;
        s_rd   = cpu_en && mmio && !cpu_wr && cpu_addr[3:0] == 4'h8;
        r_full = rxq.size() == RXD;
        if (t_pop) void'(txq.pop_front());
        if (t_push) txq.push_back(cpu_wdata[7:0]);
        if (r_pop) void'(rxq.pop_front());
        if (rx_valid && (!r_full || r_pop)) rxq.push_back(rx_data);
        if (rx_valid && r_full && !r_pop) m_ovf = 1;
        else if (s_rd) m_ovf = 0;
        m_cyc = m_cyc + 32'd1;
    endtask

    task automatic tick();
        bit mmio;
        #1;
        mmio = cpu_addr[31:28] == 4'hF;
        chk("ram_addr", ram_addr, cpu_addr[31:2]);
        chk("ram_wdata", ram_wdata, cpu_wdata);
        chk("ram_en", ram_en, cpu_en && !mmio);
        chk("ram_we", ram_we, cpu_en && !mmio && cpu_wr);
        if (synced) begin
            chk("rdata", cpu_rdata, m_rdata());
            chk("stall", cpu_stall, cpu_en && mmio && cpu_wr &&
                cpu_addr[3:0] == 4'h0 && txq.size() == TXD);
            chk("tx_valid", tx_valid, txq.size() != 0);
            if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
        end
        got_rd    = cpu_rdata;
        got_stall = cpu_stall;
        got_txv   = tx_valid;
        got_txd   = tx_data;
        got_we    = ram_we;
        got_ra    = ram_addr;
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic idle();
        cpu_en    = 0;
        cpu_wr    = 0;
        cpu_addr  = 0;
        cpu_wdata = 0;
        rx_valid  = 0;
    endtask

    task automatic access(input logic wr, input logic [31:0] a,
                          input logic [31:0] d);
        cpu_en    = 1;
        cpu_wr    = wr;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic do_reset();
        idle();
        tx_ready = 0;
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        en;
        logic        txr;
        logic [31:0] ramrd;
        logic [31:0] exp_rd;
        logic        exp_stall;
        logic        exp_txv;
        logic [7:0]  exp_txd;
        logic        exp_we;
        logic [29:0] exp_ra;
    } vec_t;

    vec_t vt[10];
    logic [31:0] r1, r2;

    initial begin
        vt[0] = '{32'hF000_0000, 32'h41, 1, 1, 1, 32'h0,
                  32'h0, 0, 0, 8'h00, 0, 30'h3C00_0000};
        vt[1] = '{32'h0, 32'h0, 0, 0, 1, 32'h5555,
                  32'h5555, 0, 1, 8'h41, 0, 30'h0};
        vt[2] = '{32'h0, 32'h0, 0, 0, 1, 32'h0,
                  32'h0, 0, 0, 8'h00, 0, 30'h0};
        vt[3] = '{32'h10, 32'hDEAD_BEEF, 1, 1, 0, 32'h1234_5678,
                  32'h1234_5678, 0, 0, 8'h00, 1, 30'h4};
        vt[4] = '{32'h10, 32'h0, 0, 1, 0, 32'hDEAD_BEEF,
                  32'hDEAD_BEEF, 0, 0, 8'h00, 0, 30'h4};
        vt[5] = '{32'hF000_0020, 32'h0, 0, 1, 0, 32'h7777,
                  32'h0, 0, 0, 8'h00, 0, 30'h3C00_0008};
        vt[6] = '{32'hF000_0008, 32'h0, 0, 1, 0, 32'h7777,
                  32'h2, 0, 0, 8'h00, 0, 30'h3C00_0002};
        vt[7] = '{32'hF000_0004, 32'h0, 0, 1, 0, 32'h7777,
                  32'hFFFF_FFFF, 0, 0, 8'h00, 0, 30'h3C00_0001};
        vt[8] = '{32'hF000_0001, 32'hAA, 1, 1, 0, 32'h7777,
                  32'h0, 0, 0, 8'h00, 0, 30'h3C00_0000};
        vt[9] = '{32'hF000_0008, 32'h0, 0, 1, 0, 32'h7777,
                  32'h2, 0, 0, 8'h00, 0, 30'h3C00_0002};

        ram_rdata = 0;
        rx_data   = 0;
        do_reset();
        chk("rst_txv", got_txv, 0);
        chk("rst_stall", got_stall, 0);

        for (int i = 0; i < 10; i++) begin
            cpu_addr  = vt[i].addr;
            cpu_wdata = vt[i].wdata;
            cpu_wr    = vt[i].wr;
            cpu_en    = vt[i].en;
            tx_ready  = vt[i].txr;
            ram_rdata = vt[i].ramrd;
            rx_valid  = 0;
            tick();
            chk($sformatf("vec%0d_rd", i), got_rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_stall", i), got_stall, vt[i].exp_stall);
            chk($sformatf("vec%0d_txv", i), got_txv, vt[i].exp_txv);
            if (vt[i].exp_txv) begin
                chk($sformatf("vec%0d_txd", i), got_txd, vt[i].exp_txd);
            end
            chk($sformatf("vec%0d_we", i), got_we, vt[i].exp_we);
            chk($sformatf("vec%0d_ra", i), got_ra, vt[i].exp_ra);
        end

        do_reset();
        for (int k = 1; k <= 8; k++) begin
            access(1, 32'hF000_0000, k);
            tick();
            chk("fill_stall", got_stall, 0);
        end
        access(0, 32'hF000_0008, 0);
        tick();
        chk("full_status", got_rd, 32'h801);
        access(1, 32'hF000_0000, 9);
        tick();
        chk("ninth_stall", got_stall, 1);
        tick();
        chk("ninth_stall_hold", got_stall, 1);
        tx_ready = 1;
        tick();
        chk("stall_with_pop", got_stall, 1);
        tx_ready = 0;
        tick();
        chk("stall_lifted", got_stall, 0);
        idle();
        tx_ready = 1;
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk("drain_valid", got_txv, 1);
            chk("drain_order", got_txd, k);
        end
        tick();
        chk("drain_empty", got_txv, 0);

        do_reset();
        for (int k = 0; k < TXD; k++) begin
            access(1, 32'hF000_0000, 32'h60 + k);
            tick();
        end
        tick();
        chk("pre_rst_stall", got_stall, 1);
        rst = 0;
        tick();
        rst = 1;
        idle();
        tx_ready = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_txv", got_txv, 0);
        end

        do_reset();
        for (int k = 0; k < 5; k++) begin
            rx_valid = 1;
            rx_data  = 8'h11 + 8'(k);
            tick();
        end
        rx_valid = 0;
        access(0, 32'hF000_0008, 0);
        tick();
        chk("ovf_status", got_rd, 32'h4E);
        for (int k = 0; k < 4; k++) begin
            access(0, 32'hF000_0004, 0);
            tick();
            chk("rx_read", got_rd, 32'h11 + k);
        end
        tick();
        chk("rx_empty_read", got_rd, 32'hFFFF_FFFF);
        access(0, 32'hF000_0008, 0);
        tick();
        chk("ovf_cleared", got_rd, 32'h2);

        do_reset();
        for (int k = 0; k < 4; k++) begin
            rx_valid = 1;
            rx_data  = 8'hA1 + 8'(k);
            tick();
        end
        access(0, 32'hF000_0004, 0);
        rx_data = 8'h99;
        tick();
        chk("full_pop_push", got_rd, 32'hA1);
        rx_valid = 0;
        access(0, 32'hF000_0008, 0);
        tick();
        chk("no_ovf_status", got_rd, 32'h46);
        for (int k = 0; k < 4; k++) begin
            access(0, 32'hF000_0004, 0);
            tick();
            chk("rx_after", got_rd, k < 3 ? 32'hA2 + k : 32'h99);
        end

        do_reset();
        idle();
        tick();
        access(0, 32'hF000_000C, 0);
        tick();
        r1 = got_rd;
        idle();
        for (int k = 0; k < 9; k++) tick();
        access(0, 32'hF000_000C, 0);
        tick();
        r2 = got_rd;
`ifdef DBG_CYCLE_COUNTER_EN
        chk("cycles_delta", r2 - r1, 32'd10);
`else
        chk("cycles_r1", r1, 32'h0);
        chk("cycles_r2", r2, 32'h0);
`endif

        got_stall = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!got_stall) begin
                cpu_en    = $urandom_range(0, 3) != 0;
                cpu_wr    = 1'($urandom_range(0, 1));
                cpu_wdata = $urandom;
                case ($urandom_range(0, 7))
                    0, 1: cpu_addr = 32'hF000_0000;
                    2: cpu_addr = 32'hF000_0004;
                    3: cpu_addr = 32'hF000_0008;
                    4: cpu_addr = 32'hF000_000C;
                    5: cpu_addr = {4'hF, 28'($urandom)};
                    default: cpu_addr = {4'($urandom_range(0, 14)),
                                         28'($urandom)};
                endcase
            end
            tx_ready  = (n % 400 < 200) ? ($urandom_range(0, 9) == 0)
                                        : 1'($urandom_range(0, 1));
            rx_valid  = $urandom_range(0, 2) == 0;
            rx_data   = 8'($urandom);
            ram_rdata = $urandom;
            rst       = $urandom_range(0, 299) != 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8, meaning TX FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter RX_DEPTH, default 4, meaning RX FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low (sampled on clk rising edge, asserted when 0).
REQ-005 cpu_addr  input  32  processor data address (byte address).
REQ-006 cpu_wdata  input  32  processor store data.
REQ-007 cpu_wr  input  1  1 = store, 0 = load; qualified by cpu_en.
REQ-008 cpu_en  input  1  data access valid this cycle.
REQ-009 cpu_rdata  output  32  load data, combinational, same cycle as access.
REQ-010 cpu_stall  output  1  access cannot complete this cycle; processor holds the access stable.
REQ-011 ram_addr  output  30  word address to data RAM, equal to cpu_addr[31:2].
REQ-012 ram_wdata  output  32  equal to cpu_wdata.
REQ-013 ram_we  input-side strobe output  1  RAM write enable.
REQ-014 ram_en  output  1  RAM enable.
REQ-015 ram_rdata  input  32  RAM read data, combinational.
REQ-016 tx_data  output  8  byte at TX FIFO head.
REQ-017 tx_valid  output  1  TX FIFO not empty.
REQ-018 tx_ready  input  1  SPART accepts tx_data this cycle.
REQ-019 rx_data  input  8  received byte from SPART.
REQ-020 rx_valid  input  1  one-cycle pulse: rx_data is valid.

Function
REQ-021 Decode: cpu_addr[31:28]==4'hF selects MMIO; any other value selects RAM.
REQ-022 RAM path: ram_en = cpu_en & ~mmio; ram_we = ram_en & cpu_wr; for RAM loads, cpu_rdata = ram_rdata; zero added latency.
REQ-023 MMIO map (cpu_addr[3:0]): 0x0 TXDATA (W), 0x4 RXDATA (R), 0x8 STATUS (R), 0xC CYCLES (R); other MMIO addresses: reads return 0, writes ignored.
REQ-024 TXDATA store pushes cpu_wdata[7:0] at the clock edge if the TX FIFO is not full.
REQ-025 TXDATA store while TX FIFO is full: cpu_stall=1 combinationally, no push; the store completes on the first cycle the FIFO is not full. A pop in the same cycle does not lift the stall.
REQ-026 TX drain: pop on tx_valid & tx_ready; FIFO order; tx_data holds until popped.
REQ-027 RXDATA load: cpu_rdata = {24'b0, head byte}, pop at edge; if RX empty, cpu_rdata = 32'hFFFF_FFFF, no pop, no stall.
REQ-028 rx_valid with RX FIFO not full: push rx_data.
REQ-029 rx_valid with RX FIFO full: byte dropped, sticky rx_ovf set; exception: if a CPU RXDATA pop occurs in the same cycle, push and pop both happen, nothing is dropped.
REQ-030 STATUS = {20'b0, tx_count[3:0], rx_count[3:0], rx_ovf, rx_avail, tx_empty, tx_full} (bits 0..3 = tx_full, tx_empty, rx_avail, rx_ovf); a STATUS load clears rx_ovf at the edge, and a simultaneous overflow re-sets it.
REQ-031 FIFO pointers wrap modulo depth; count ranges 0..DEPTH, with full = (count==DEPTH).
REQ-032 cpu_stall is 0 for every access except the case in REQ-025; loads with cpu_en=0 have no side effects.

Reset
REQ-033 While rst=0: both FIFOs empty, rx_ovf=0, cycle counter=0, tx_valid=0, cpu_stall=0; pointer and count registers are cleared.
REQ-034 Reset asserted mid-stall or mid-drain discards all FIFO contents with no further tx_valid until a new push.
REQ-035 Combinational outputs (ram_*, cpu_rdata) follow inputs during reset; RAM writes are not gated by reset.

Configuration
REQ-036 Macro DBG_CYCLE_COUNTER_EN: when defined, a 32-bit free-running counter increments every cycle after reset, wraps from 0xFFFF_FFFF to 0, and reads at CYCLES.
REQ-037 When DBG_CYCLE_COUNTER_EN is not defined, no counter is implemented and CYCLES reads 0.

Verification
REQ-038 Store 0x0000_0041 to 0xF000_0000 with tx_ready=1 -> next cycle tx_valid=1, tx_data=0x41; popped the following edge; cpu_stall=0 throughout.
REQ-039 tx_ready=0, store 9 bytes to TXDATA (TX_DEPTH=8) -> 9th store sees cpu_stall=1; STATUS bit0=1, tx_count=8; raise tx_ready for 1 cycle -> stall drops the next cycle, 9th byte is enqueued, bytes drain in order.
REQ-040 Pulse rx_valid with 0x11..0x15 (RX_DEPTH=4), no reads -> STATUS rx_ovf=1, rx_count=4; RXDATA reads return 0x11..0x14 then 0xFFFF_FFFF; STATUS read clears rx_ovf.
REQ-041 RX full, rx_valid=0x99 in the same cycle as an RXDATA load -> load returns the head, 0x99 is enqueued, rx_ovf stays 0.
REQ-042 Store 0xDEAD_BEEF to 0x0000_0010, then load -> ram_we=1, ram_addr=4, load returns ram_rdata; MMIO load 0xF000_0020 -> 0.
REQ-043 With DBG_CYCLE_COUNTER_EN defined, release reset and read CYCLES at cycles N and N+10 -> difference is 10; without the macro, both reads return 0.
